// File: rtl/br_perf_counter.sv
// br_perf_counter
//   Branch performance counters for the branch functional unit. The unit counts every
//   resolved branch and every mispredict. The cumulative counts saturate at all-ones, and a
//   snapshot of each WINDOW-branch window is offered over a valid/ready handshake.
//
// Optional feature: define BR_PERF_TAKEN_EN to add taken-branch counting
//   (perf_br_taken_cnt, snap_taken_cnt). When it is undefined, br_taken is unused.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   br_resolve_valid         a branch resolves this cycle
//   br_mispredict, br_taken  qualifiers, valid only with br_resolve_valid
//   perf_clear               zero all counters and drop the open window and pending snapshot
//   perf_br_cnt              cumulative resolved branches (saturating)
//   perf_br_mispredict_cnt   cumulative mispredicts (saturating)
//   snap_valid/snap_ready    snapshot handshake
//   snap_br_cnt              branches in the snapshot window (WINDOW when valid)
//   snap_mispredict_cnt      mispredicts in the snapshot window
//   snap_drop_cnt            windows lost while a snapshot was pending (saturating)
module br_perf_counter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned WINDOW    = 1024,
    localparam int unsigned WIN_WIDTH = $clog2(WINDOW + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br_resolve_valid,
    input  logic                 br_mispredict,
    input  logic                 br_taken,
    input  logic                 perf_clear,
    output logic [CNT_WIDTH-1:0] perf_br_cnt,
    output logic [CNT_WIDTH-1:0] perf_br_mispredict_cnt,
    output logic                 snap_valid,
    input  logic                 snap_ready,
    output logic [WIN_WIDTH-1:0] snap_br_cnt,
    output logic [WIN_WIDTH-1:0] snap_mispredict_cnt,
`ifdef BR_PERF_TAKEN_EN
    output logic [CNT_WIDTH-1:0] perf_br_taken_cnt,
    output logic [WIN_WIDTH-1:0] snap_taken_cnt,
`endif
    output logic [CNT_WIDTH-1:0] snap_drop_cnt
);

    localparam logic [WIN_WIDTH-1:0] WinLast = WIN_WIDTH'(WINDOW - 1);
    localparam logic [WIN_WIDTH-1:0] WinFull = WIN_WIDTH'(WINDOW);

    typedef enum logic {StEmpty, StFull} snap_state_e;

    snap_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mp_cnt_q, mp_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [WIN_WIDTH-1:0] win_br_q, win_br_d;
    logic [WIN_WIDTH-1:0] win_mp_q, win_mp_d;
    logic [WIN_WIDTH-1:0] snap_br_q, snap_br_d;
    logic [WIN_WIDTH-1:0] snap_mp_q, snap_mp_d;
    logic                 ev, mp_ev, win_done;
    logic [WIN_WIDTH-1:0] closed_mp;

`ifdef BR_PERF_TAKEN_EN
    logic [CNT_WIDTH-1:0] tk_cnt_q, tk_cnt_d;
    logic [WIN_WIDTH-1:0] win_tk_q, win_tk_d;
    logic [WIN_WIDTH-1:0] snap_tk_q, snap_tk_d;
    logic                 tk_ev;
    logic [WIN_WIDTH-1:0] closed_tk;
`else
    logic unused_br_taken;
    assign unused_br_taken = br_taken;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                     input logic en);
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    always_comb begin
        ev        = br_resolve_valid;
        mp_ev     = br_resolve_valid & br_mispredict;
        // The completing event belongs to the window it closes.
        win_done  = ev && (win_br_q == WinLast);
        closed_mp = win_mp_q + WIN_WIDTH'(mp_ev);

        state_d    = state_q;
        br_cnt_d   = sat_inc(br_cnt_q, ev);
        mp_cnt_d   = sat_inc(mp_cnt_q, mp_ev);
        drop_cnt_d = drop_cnt_q;
        win_br_d   = win_done ? '0 : win_br_q + WIN_WIDTH'(ev);
        win_mp_d   = win_done ? '0 : closed_mp;
        snap_br_d  = snap_br_q;
        snap_mp_d  = snap_mp_q;
`ifdef BR_PERF_TAKEN_EN
        tk_ev     = br_resolve_valid & br_taken;
        closed_tk = win_tk_q + WIN_WIDTH'(tk_ev);
        tk_cnt_d  = sat_inc(tk_cnt_q, tk_ev);
        win_tk_d  = win_done ? '0 : closed_tk;
        snap_tk_d = snap_tk_q;
`endif

        unique case (state_q)
            StEmpty: begin
                if (win_done) state_d = StFull;
            end
            StFull: begin
                if (snap_ready) begin
                    if (!win_done) state_d = StEmpty;
                end else if (win_done) begin
                    drop_cnt_d = sat_inc(drop_cnt_q, 1'b1);
                end
            end
            default: state_d = StEmpty;
        endcase

        // Load whenever the slot is free now or is being freed by this handshake.
        if (win_done && ((state_q == StEmpty) || snap_ready)) begin
            snap_br_d = WinFull;
            snap_mp_d = closed_mp;
`ifdef BR_PERF_TAKEN_EN
            snap_tk_d = closed_tk;
`endif
        end

        if (perf_clear) begin
            state_d    = StEmpty;
            br_cnt_d   = '0;
            mp_cnt_d   = '0;
            drop_cnt_d = '0;
            win_br_d   = '0;
            win_mp_d   = '0;
            snap_br_d  = '0;
            snap_mp_d  = '0;
`ifdef BR_PERF_TAKEN_EN
            tk_cnt_d  = '0;
            win_tk_d  = '0;
            snap_tk_d = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StEmpty;
            br_cnt_q   <= '0;
            mp_cnt_q   <= '0;
            drop_cnt_q <= '0;
            win_br_q   <= '0;
            win_mp_q   <= '0;
            snap_br_q  <= '0;
            snap_mp_q  <= '0;
`ifdef BR_PERF_TAKEN_EN
            tk_cnt_q  <= '0;
            win_tk_q  <= '0;
            snap_tk_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            br_cnt_q   <= br_cnt_d;
            mp_cnt_q   <= mp_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            win_br_q   <= win_br_d;
            win_mp_q   <= win_mp_d;
            snap_br_q  <= snap_br_d;
            snap_mp_q  <= snap_mp_d;
`ifdef BR_PERF_TAKEN_EN
            tk_cnt_q  <= tk_cnt_d;
            win_tk_q  <= win_tk_d;
            snap_tk_q <= snap_tk_d;
`endif
        end
    end

    assign perf_br_cnt            = br_cnt_q;
    assign perf_br_mispredict_cnt = mp_cnt_q;
    assign snap_valid             = (state_q == StFull);
    assign snap_br_cnt            = snap_br_q;
    assign snap_mispredict_cnt    = snap_mp_q;
    assign snap_drop_cnt          = drop_cnt_q;
`ifdef BR_PERF_TAKEN_EN
    assign perf_br_taken_cnt = tk_cnt_q;
    assign snap_taken_cnt    = snap_tk_q;
`endif

endmodule

// File: tb/tb_br_perf_counter.sv
// Testbench for br_perf_counter.
// The main instance uses WINDOW=4 and CNT_WIDTH=32. The small instance uses WINDOW=1 and
// CNT_WIDTH=4 to exercise saturation.
module tb_br_perf_counter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Main DUT signals
    logic        rv, mp, tk, clr, rdy;
    logic [31:0] br_cnt, mp_cnt, drop_cnt;
    logic        sv;
    logic [2:0]  sbr, smp;
`ifdef BR_PERF_TAKEN_EN
    logic [31:0] tk_cnt;
    logic [2:0]  stk;
    logic [3:0]  tk_cnt2;
    logic [0:0]  stk2;
`endif

    // Small DUT signals
    logic        rv2, mp2, rdy2;
    logic [3:0]  br_cnt2, mp_cnt2, drop_cnt2;
    logic        sv2;
    logic [0:0]  sbr2, smp2;

    br_perf_counter #(.CNT_WIDTH(32), .WINDOW(4)) u_dut (
        .clk                    (clk),
        .rst                    (rst),
        .br_resolve_valid       (rv),
        .br_mispredict          (mp),
        .br_taken               (tk),
        .perf_clear             (clr),
        .perf_br_cnt            (br_cnt),
        .perf_br_mispredict_cnt (mp_cnt),
        .snap_valid             (sv),
        .snap_ready             (rdy),
        .snap_br_cnt            (sbr),
        .snap_mispredict_cnt    (smp),
`ifdef BR_PERF_TAKEN_EN
        .perf_br_taken_cnt      (tk_cnt),
        .snap_taken_cnt         (stk),
`endif
        .snap_drop_cnt          (drop_cnt)
    );

    br_perf_counter #(.CNT_WIDTH(4), .WINDOW(1)) u_dut_small (
        .clk                    (clk),
        .rst                    (rst),
        .br_resolve_valid       (rv2),
        .br_mispredict          (mp2),
        .br_taken               (1'b0),
        .perf_clear             (1'b0),
        .perf_br_cnt            (br_cnt2),
        .perf_br_mispredict_cnt (mp_cnt2),
        .snap_valid             (sv2),
        .snap_ready             (rdy2),
        .snap_br_cnt            (sbr2),
        .snap_mispredict_cnt    (smp2),
`ifdef BR_PERF_TAKEN_EN
        .perf_br_taken_cnt      (tk_cnt2),
        .snap_taken_cnt         (stk2),
`endif
        .snap_drop_cnt          (drop_cnt2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rv, mp, clr, rdy;
        bit          push;      // this vector closes a window whose snapshot will be accepted
        int unsigned psmp;      // mispredicts expected in that snapshot
        int unsigned ebr, emp;  // expected cumulative counts after the edge
        bit          ev;        // expected snap_valid after the edge
        int unsigned edrop;
    } vec_t;

    vec_t        vecs[$];
    int unsigned sb_q[$];  // expected snap_mispredict_cnt of snapshots, in acceptance order

    function automatic vec_t mk(bit r, bit m, bit c, bit y, bit p, int unsigned ps,
                                int unsigned b, int unsigned e, bit v, int unsigned d);
        vec_t t;
        t.rv = r; t.mp = m; t.clr = c; t.rdy = y; t.push = p; t.psmp = ps;
        t.ebr = b; t.emp = e; t.ev = v; t.edrop = d;
        return t;
    endfunction

    task automatic check(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(vec_t t, int idx);
        rv = t.rv; mp = t.mp; tk = $urandom_range(0, 1); clr = t.clr; rdy = t.rdy;
        #1;
        // Handshake happens at the coming edge: score the presented snapshot now.
        if (sv && rdy && !t.clr) begin
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d unexpected_snapshot", idx), 1, 0);
            end else begin
                int unsigned e;
                e = sb_q.pop_front();
                check($sformatf("v%0d snap_br_cnt", idx), sbr, 4);
                check($sformatf("v%0d snap_mispredict_cnt", idx), smp, e);
            end
        end
        if (t.clr) sb_q.delete();
        if (t.push) sb_q.push_back(t.psmp);
        @(posedge clk);
        #1;
        check($sformatf("v%0d perf_br_cnt", idx), br_cnt, t.ebr);
        check($sformatf("v%0d perf_br_mispredict_cnt", idx), mp_cnt, t.emp);
        check($sformatf("v%0d snap_valid", idx), sv, t.ev);
        check($sformatf("v%0d snap_drop_cnt", idx), drop_cnt, t.edrop);
    endtask

    initial begin
        rst = 1'b0; rv = 0; mp = 0; tk = 0; clr = 0; rdy = 0;
        rv2 = 0; mp2 = 0; rdy2 = 0;

        //             rv mp clr rdy push psmp  br  mp  v drop
        // Three resolves, two mispredicts, then an ignored qualifier
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    1,  1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    2,  2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    3,  2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,    3,  2, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 2,    4,  2, 1, 0));
        // Window with one mispredict, ready held: valid for exactly one cycle
        vecs.push_back(mk(1, 1, 0, 1, 0, 0,    5,  3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    6,  3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0,    7,  3, 0, 0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 1,    8,  3, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,    8,  3, 0, 0));
        // Ready low, 8 resolves: the second window is dropped, the first is held
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    9,  4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   10,  4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   11,  4, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 1,   12,  4, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   13,  5, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   14,  6, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   15,  7, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   16,  8, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   16,  8, 0, 1));
        // Handshake coincides with a window completion
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   17,  8, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   18,  8, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   19,  8, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1,   20,  9, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   21, 10, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   22, 11, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,   23, 12, 1, 1));
        vecs.push_back(mk(1, 0, 0, 1, 1, 3,   24, 12, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   24, 12, 0, 1));
        // Fill, drop one more, then clear coincident with a resolve while full
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   25, 12, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   26, 12, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   27, 12, 0, 1));
        vecs.push_back(mk(1, 1, 0, 0, 1, 1,   28, 13, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   29, 13, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   30, 13, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   31, 13, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   32, 13, 1, 2));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,    0,  0, 0, 0));
        // Window restarts from zero after the clear
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    1,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    2,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,    3,  0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,    4,  0, 1, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0,    5,  1, 1, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset perf_br_cnt", br_cnt, 0);
        check("reset perf_br_mispredict_cnt", mp_cnt, 0);
        check("reset snap_valid", sv, 0);
        check("reset snap_br_cnt", sbr, 0);
        check("reset snap_mispredict_cnt", smp, 0);
        check("reset snap_drop_cnt", drop_cnt, 0);
        check("reset small snap_valid", sv2, 0);
        rst = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Reset mid-window while full, with a resolve in the same cycle
        rv = 1; mp = 1; rdy = 0; clr = 0; rst = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        check("rst perf_br_cnt", br_cnt, 0);
        check("rst perf_br_mispredict_cnt", mp_cnt, 0);
        check("rst snap_valid", sv, 0);
        check("rst snap_drop_cnt", drop_cnt, 0);
        check("rst snap_mispredict_cnt", smp, 0);
        rst = 1'b1; rv = 0; mp = 0;
        // Three resolves must not complete a window after reset
        rv = 1;
        repeat (3) @(posedge clk);
        #1;
        rv = 0;
        check("post-rst perf_br_cnt", br_cnt, 3);
        check("post-rst snap_valid", sv, 0);

        // WINDOW=1, CNT_WIDTH=4: every event closes a window, counters saturate at 15
        rv2 = 1; mp2 = 1; rdy2 = 0;
        @(posedge clk);
        #1;
        check("small first perf_br_cnt", br_cnt2, 1);
        check("small first snap_valid", sv2, 1);
        check("small first snap_br_cnt", sbr2, 1);
        check("small first snap_mispredict_cnt", smp2, 1);
        check("small first snap_drop_cnt", drop_cnt2, 0);
        repeat (19) @(posedge clk);
        #1;
        check("small sat perf_br_cnt", br_cnt2, 15);
        check("small sat perf_br_mispredict_cnt", mp_cnt2, 15);
        check("small sat snap_drop_cnt", drop_cnt2, 15);
        check("small sat snap_valid", sv2, 1);
        rv2 = 0; mp2 = 0; rdy2 = 1;
        @(posedge clk);
        #1;
        check("small accept snap_valid", sv2, 0);
        check("small hold perf_br_cnt", br_cnt2, 15);

        check("scoreboard drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
